// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types, field positions and helpers for the MMU PAR loader.
// Address and identity-map word construction live here so all users agree on the layout.
package mmu_pkg;

    typedef enum logic [2:0] {IDLE, WR, RD, CMP, FIN} state_e;

    localparam int          PAR_IDX_W    = 3;
    localparam int          SEL_BIT      = 4;
    localparam logic [15:0] REG_BASE_DEF = 16'hFF80;
    localparam int          PAR_WR_BIT   = 15;
    localparam int          PAR_BASE_W   = 15;

    // Kernel PARs occupy base+0..E, user PARs base+10..1E, one word apart.
    function automatic logic [15:0] par_addr(input logic [15:0] base, input logic [3:0] c);
        return base | (16'(c[3]) << SEL_BIT) | (16'(c[PAR_IDX_W-1:0]) << 1);
    endfunction

    // Identity map: page i maps to block i*128; masked pages lose write permission.
    function automatic logic [15:0] ident_word(input logic [7:0] mask, input logic [PAR_IDX_W-1:0] i);
        logic [15:0] w;
        w                   = '0;
        w[PAR_WR_BIT]       = ~mask[i];
        w[PAR_BASE_W-1:0]   = PAR_BASE_W'({i, 7'd0});
        return w;
    endfunction

endpackage

// File: rtl/par_shadow.sv
// par_shadow: 16x16 copy of every PAR word written, read back during verify.
// Unreset on purpose: each entry is written before the verify pass reads it.
module par_shadow (
    input  logic        clk,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [3:0]  raddr_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [16];

    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmu_par_loader.sv
// mmu_par_loader: programs all 16 MMU PARs, optionally verifies them by readback,
// then enables translation. All register-port outputs are registered.
module mmu_par_loader
    import mmu_pkg::*;
#(
    parameter logic [15:0] REG_BASE      = REG_BASE_DEF,
    parameter logic [7:0]  ROM_PAGE_MASK = 8'hF0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        src_sel,
    input  logic        verify_en,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [15:0] src_data,
    output logic        mmu_ce,
    output logic        mmu_regwr,
    output logic        mmu_regrd,
    output logic [15:0] mmu_addr,
    output logic [15:0] mmu_wdata,
    input  logic [15:0] mmu_rdata,
    input  logic        mmu_valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  err_index,
    output logic        enable_o
);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        sel_q, ver_q, last_q;
    logic        src_ready_q, ce_q, regwr_q, regrd_q, busy_q, done_q, error_q, enable_q;
    logic [15:0] addr_q, wdata_q;
    logic [3:0]  err_index_q;

    logic        start_go, wr_go, issue, match;
    logic [3:0]  wr_idx;
    logic [15:0] wr_word, shadow_rd;

    // An issue edge loads the strobe so it is visible for the following cycle;
    // internal mode issues index 0 on the start edge itself.
    always_comb begin
        start_go = (state_q == IDLE) && start;
        wr_go    = (state_q == WR) && !last_q && (!sel_q || (src_valid && src_ready_q));
        issue    = (start_go && !src_sel) || wr_go;
        wr_idx   = start_go ? 4'd0 : cnt_q;
        wr_word  = (state_q == WR && sel_q) ? src_data : ident_word(ROM_PAGE_MASK, wr_idx[2:0]);
        match    = mmu_valid && (mmu_rdata == shadow_rd);
    end

    par_shadow u_shadow (
        .clk     (clk),
        .we_i    (issue),
        .waddr_i (wr_idx),
        .wdata_i (wr_word),
        .raddr_i (cnt_q),
        .rdata_o (shadow_rd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            ver_q       <= 1'b0;
            last_q      <= 1'b0;
            src_ready_q <= 1'b0;
            ce_q        <= 1'b0;
            regwr_q     <= 1'b0;
            regrd_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            enable_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_index_q <= '0;
        end else begin
            ce_q    <= 1'b0;
            regwr_q <= 1'b0;
            regrd_q <= 1'b0;
            done_q  <= 1'b0;
            if (issue) begin
                ce_q    <= 1'b1;
                regwr_q <= 1'b1;
                addr_q  <= par_addr(REG_BASE, wr_idx);
                wdata_q <= wr_word;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q     <= WR;
                    busy_q      <= 1'b1;
                    sel_q       <= src_sel;
                    ver_q       <= verify_en;
                    last_q      <= 1'b0;
                    error_q     <= 1'b0;
                    enable_q    <= 1'b0;
                    err_index_q <= '0;
                    cnt_q       <= src_sel ? 4'd0 : 4'd1;
                    src_ready_q <= src_sel;
                end
                WR: if (last_q) begin
                    cnt_q   <= '0;
                    state_q <= ver_q ? RD : FIN;
                    done_q  <= !ver_q;
                    ce_q    <= ver_q;
                    regrd_q <= ver_q;
                    addr_q  <= ver_q ? par_addr(REG_BASE, 4'd0) : addr_q;
                end else if (issue) begin
                    last_q      <= (cnt_q == 4'd15);
                    src_ready_q <= src_ready_q && (cnt_q != 4'd15);
                    cnt_q       <= (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                end
                RD: state_q <= CMP;
                CMP: if (!match) begin
                    error_q     <= 1'b1;
                    err_index_q <= cnt_q;
                    done_q      <= 1'b1;
                    state_q     <= FIN;
                end else if (cnt_q == 4'd15) begin
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end else begin
                    cnt_q   <= cnt_q + 4'd1;
                    ce_q    <= 1'b1;
                    regrd_q <= 1'b1;
                    addr_q  <= par_addr(REG_BASE, cnt_q + 4'd1);
                    state_q <= RD;
                end
                FIN: begin
                    busy_q   <= 1'b0;
                    enable_q <= !error_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_ready = src_ready_q;
    assign mmu_ce    = ce_q;
    assign mmu_regwr = regwr_q;
    assign mmu_regrd = regrd_q;
    assign mmu_addr  = addr_q;
    assign mmu_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_index_q;
    assign enable_o  = enable_q;

endmodule

// File: tb/tb_mmu_par_loader.sv
// tb_mmu_par_loader: directed checks of the PAR loader against a small MMU register model.
module tb_mmu_par_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, src_sel = 1'b0, verify_en = 1'b0;
    logic        src_valid = 1'b0, src_ready;
    logic [15:0] src_data = '0;
    logic        mmu_ce, mmu_regwr, mmu_regrd;
    logic [15:0] mmu_addr, mmu_wdata;
    logic [15:0] mmu_rdata = '0;
    logic        mmu_valid = 1'b0;
    logic        busy, done, error, enable_o;
    logic [3:0]  err_index;

    mmu_par_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_sel(src_sel), .verify_en(verify_en),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .mmu_ce(mmu_ce), .mmu_regwr(mmu_regwr), .mmu_regrd(mmu_regrd),
        .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata), .mmu_rdata(mmu_rdata), .mmu_valid(mmu_valid),
        .busy(busy), .done(done), .error(error), .err_index(err_index), .enable_o(enable_o)
    );

    always #5 clk = ~clk;

    int vecs = 0, miss = 0;
    int cyc = 0, base = 0;
    int wr_n, rd_n, done_cyc, done_n, both_hi, addr_bad, stall_bad, n;
    logic done_seen, stream_on, corrupt, hs_q;
    logic [15:0] par [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        hs_q <= src_valid && src_ready;
        mmu_valid <= mmu_ce && mmu_regrd;
        if (mmu_ce && mmu_regwr) par[{mmu_addr[4], mmu_addr[3:1]}] <= mmu_wdata;
        if (mmu_ce && mmu_regrd)
            mmu_rdata <= par[{mmu_addr[4], mmu_addr[3:1]}]
                       ^ ((corrupt && mmu_addr[4:1] == 4'hA) ? 16'h0040 : 16'h0000);
    end

    // Bus monitor and stream source: write/read ordering, overlap, and stall behaviour.
    always @(negedge clk) begin
        if (mmu_regwr && mmu_regrd) both_hi++;
        if (mmu_regwr) begin
            if (mmu_addr !== 16'hFF80 + 16'(2 * wr_n)) addr_bad++;
            wr_n++;
        end
        if (mmu_regrd) begin
            if (mmu_addr !== 16'hFF80 + 16'(2 * rd_n)) addr_bad++;
            rd_n++;
        end
        if (done) begin
            done_n++;
            done_seen = 1'b1;
            done_cyc  = cyc - base;
        end
        if (stream_on) begin
            if (mmu_regwr !== hs_q) stall_bad++;
            if (hs_q) n++;
            src_valid = ~src_valid;
            src_data  = 16'h1000 + 16'(n);
        end else begin
            src_valid = 1'b0;
        end
    end

    task automatic run(input logic s, input logic v, input logic c, input logic x);
        wr_n = 0; rd_n = 0; done_n = 0; done_cyc = 0; addr_bad = 0; stall_bad = 0; n = 0;
        done_seen = 1'b0; corrupt = c; stream_on = s;
        src_sel = s; verify_en = v;
        base = cyc; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && !done_seen; i++) begin
            start = (x && (cyc - base == 5));
            tick();
        end
        start = 1'b0;
        chk("done_seen", 32'(done_seen), 1);
        tick();
        stream_on = 1'b0;
    endtask

    initial begin
        both_hi = 0; wr_n = 0; rd_n = 0; done_n = 0; done_cyc = 0; addr_bad = 0; stall_bad = 0; n = 0;
        done_seen = 1'b0; stream_on = 1'b0; corrupt = 1'b0;
        tick(); tick();
        chk("rst_flags", 32'({mmu_ce, mmu_regwr, mmu_regrd, busy, done, error, enable_o, src_ready}), 0);
        chk("rst_addr", 32'(mmu_addr), 0);
        chk("rst_wdata", 32'(mmu_wdata), 0);
        chk("rst_erridx", 32'(err_index), 0);
        reset_n = 1'b1;
        tick();

        run(1'b0, 1'b1, 1'b0, 1'b0);
        chk("int_done_cyc", 32'(done_cyc), 49);
        chk("int_enable", 32'(enable_o), 1);
        chk("int_error", 32'(error), 0);
        chk("int_busy", 32'(busy), 0);
        chk("int_wr_n", 32'(wr_n), 16);
        chk("int_rd_n", 32'(rd_n), 16);
        chk("int_addr", 32'(addr_bad), 0);
        chk("int_k0", 32'(par[0]), 32'h8000);
        chk("int_k3", 32'(par[3]), 32'h8180);
        chk("int_k4", 32'(par[4]), 32'h0200);
        chk("int_u7", 32'(par[15]), 32'h0380);
        chk("int_done_n", 32'(done_n), 1);

        run(1'b1, 1'b1, 1'b0, 1'b0);
        chk("str_wr_n", 32'(wr_n), 16);
        chk("str_rd_n", 32'(rd_n), 16);
        chk("str_addr", 32'(addr_bad), 0);
        chk("str_stall", 32'(stall_bad), 0);
        chk("str_error", 32'(error), 0);
        chk("str_enable", 32'(enable_o), 1);
        chk("str_k0", 32'(par[0]), 32'h1000);
        chk("str_u1", 32'(par[9]), 32'h1009);
        chk("str_u7", 32'(par[15]), 32'h100F);

        run(1'b0, 1'b1, 1'b1, 1'b0);
        chk("bad_error", 32'(error), 1);
        chk("bad_erridx", 32'(err_index), 32'hA);
        chk("bad_done_cyc", 32'(done_cyc), 39);
        chk("bad_enable", 32'(enable_o), 0);
        chk("bad_rd_n", 32'(rd_n), 11);
        tick(); tick();
        chk("bad_enable_late", 32'(enable_o), 0);

        run(1'b0, 1'b0, 1'b0, 1'b0);
        chk("nov_done_cyc", 32'(done_cyc), 17);
        chk("nov_rd_n", 32'(rd_n), 0);
        chk("nov_enable", 32'(enable_o), 1);
        chk("nov_error", 32'(error), 0);

        // Abort mid-verify: assert reset during the RD cycle for index 5.
        wr_n = 0; rd_n = 0; addr_bad = 0; done_seen = 1'b0; corrupt = 1'b0;
        src_sel = 1'b0; verify_en = 1'b1; base = cyc; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !(mmu_regrd && mmu_addr[4:1] == 4'd5); i++) tick();
        chk("ar_in_rd5", 32'({mmu_regrd, mmu_addr[4:1]}), 32'h15);
        reset_n = 1'b0;
        #1;
        chk("ar_flags", 32'({mmu_ce, mmu_regwr, mmu_regrd, busy, done, error, enable_o, src_ready}), 0);
        chk("ar_addr", 32'(mmu_addr), 0);
        chk("ar_wdata", 32'(mmu_wdata), 0);
        tick();
        reset_n = 1'b1;
        tick();
        run(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ar_re_done_cyc", 32'(done_cyc), 49);
        chk("ar_re_enable", 32'(enable_o), 1);

        run(1'b0, 1'b1, 1'b0, 1'b1);
        chk("sw_done_cyc", 32'(done_cyc), 49);
        chk("sw_wr_n", 32'(wr_n), 16);
        chk("sw_done_n", 32'(done_n), 1);
        chk("sw_enable", 32'(enable_o), 1);
        tick(); tick();
        chk("sw_idle", 32'(busy), 0);
        chk("no_overlap", 32'(both_hi), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
